dmem_arbiter_ctrl: RTL and testbench
====================================

Name: dmem_arbiter_ctrl

Overview:
Controller that shares the single-port 32-bit data RAM (256 words, unregistered q, address sampled on clock) between two requesters: port 0 is the pipeline MEM stage and port 1 is the loader/debug port. It arbitrates round-robin and issues one RAM transaction at a time. Byte and halfword stores are executed as read-modify-write because the RAM has no byte enables. It also reports misaligned and out-of-range accesses.

Parameters:
D_WIDTH, 32, data width; fixed at 32 because byte-lane logic assumes 4 lanes
A_WIDTH, 8, RAM word-address width (2**A_WIDTH words)
ADDR_W, 32, requester byte-address width

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
req0 / req1  in  1  request valid; held with its fields stable until ack
we0 / we1  in  1  1 = store, 0 = load
size0 / size1  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
addr0 / addr1  in  ADDR_W  byte address
wdata0 / wdata1  in  D_WIDTH  store data, right-justified (byte in [7:0], half in [15:0])
ack0 / ack1  out  1  one-cycle completion pulse
err0 / err1  out  1  high together with ack when the access was rejected
rdata  out  D_WIDTH  aligned word for the last completed load; valid in the ack cycle, then held
busy  out  1  high whenever state is not IDLE
ram_addr  out  A_WIDTH  to RAM address
ram_data  out  D_WIDTH  to RAM data
ram_wren  out  1  to RAM wren
ram_q  in  D_WIDTH  from RAM q

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- All outputs are registered. Reset values: ack*/err* = 0, rdata = 0, busy = 0, ram_addr = 0, ram_data = 0, ram_wren = 0, state = IDLE, last_grant = 1 (port 0 wins the first tie).
- States are IDLE, ACCESS, RWAIT and WRITE.
- IDLE, at edge E0:
  - Exactly one req high: that port is granted.
  - Both high: the port != last_grant is granted, and last_grant is updated.
  - On grant, latch we, size, addr and wdata. ram_addr <= addr[A_WIDTH+1:2].
  - Word store: ram_data <= wdata and ram_wren <= 1.
  - Go to ACCESS.
- Error check, done in IDLE at grant:
  - Error conditions: addr[ADDR_W-1:A_WIDTH+2] != 0, half with addr[0] = 1, or word with addr[1:0] != 0.
  - On error: no RAM access, ram_wren stays 0, and ack = err = 1 at E1. Go to IDLE via ACCESS.
- ACCESS, at E1 (the RAM samples at this edge):
  - Word store: ack at E1, ram_wren <= 0, go to IDLE. Grant-to-ack latency is 2 edges.
  - Load or sub-word store: go to RWAIT.
- RWAIT (ram_q is valid during this cycle), at E2:
  - Load: rdata <= ram_q, ack, go to IDLE. Latency is 3 edges.
  - Sub-word store: compute the merged word into ram_data, set ram_wren <= 1, go to WRITE.
    - Byte merge: lane addr[1:0] gets wdata[7:0].
    - Half merge: lane addr[1] gets wdata[15:0].
    - Little-endian; all other lanes come from ram_q.
- WRITE, at E3: the RAM writes. Ack, ram_wren <= 0, go to IDLE. Latency is 4 edges.
- ack/err are high for exactly one cycle. The earliest next grant is the edge ending the ack cycle, i.e. the requester may keep req high for back-to-back accesses.
- A request arriving while busy is ignored until IDLE. The non-granted requester simply waits.
- A load returns the full aligned word; sign/zero extraction is the requester's job.
- Reset sampled mid-transaction: everything returns to reset values at that edge and no ack is issued.
  - A write whose ram_wren is already 1 at that edge still completes, because the RAM samples at the same edge.
  - No later write is issued.
- Only the current owner ever drives ack/err, so both acks are never high together.

Test Plan:
1. Port0 word store 0x00000010 <- 0xDEADBEEF, then word load 0x10 -> store ack 2 edges after grant; ram_wren high exactly 1 cycle with ram_addr = 0x04; load ack 3 edges after grant with rdata = 0xDEADBEEF.
2. Word 0x20 = 0x11223344. Port1 byte store addr 0x22, wdata 0xAA, then half store addr 0x20, wdata 0xBEEF -> word becomes 0x11AA3344, then 0x11AABEEF; each store acks after 4 edges with a single wren pulse.
3. req0 and req1 raised in the same cycle, both held continuously with word loads -> grants go port0, port1, port0, port1; ack0/ack1 never coincide.
4. Port0 half load at addr 0x05, then word store at addr 0x402 (A_WIDTH = 8) -> ack0 = err0 = 1 at E1 each time; ram_wren is never asserted; RAM contents unchanged.
5. reset_n pulled low during RWAIT of a byte store -> no ack; ram_wren stays 0; target word unchanged; busy = 0 next cycle; a subsequent req0 is served normally.
6. Port1 word load outstanding while req0 rises mid-transaction -> port0 is granted only at the edge ending ack1; port0's result rdata is correct.

Source files
------------

// File: rtl/dmem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_ctrl
// Purpose  : Round-robin arbiter sharing one single-port data RAM between the
//            MEM stage (port 0) and the loader/debug port (port 1). Sub-word
//            stores are read-modify-write; bad addresses are rejected.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter_ctrl #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 8,
    parameter int ADDR_W  = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               we0,
    input  logic               we1,
    input  logic [1:0]         size0,
    input  logic [1:0]         size1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [D_WIDTH-1:0] wdata0,
    input  logic [D_WIDTH-1:0] wdata1,
    output logic               ack0,
    output logic               ack1,
    output logic               err0,
    output logic               err1,
    output logic [D_WIDTH-1:0] rdata,
    output logic               busy,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_data,
    output logic               ram_wren,
    input  logic [D_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RWAIT  = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t r_state, w_state;

    // Transaction context latched at grant
    logic               r_last_grant, w_last_grant;
    logic               r_owner,      w_owner;
    logic               r_we,         w_we;
    logic [1:0]         r_size,       w_size;
    logic [1:0]         r_lane,       w_lane;
    logic [15:0]        r_wdata16,    w_wdata16;
    logic               r_err,        w_err;

    // Next values of the registered outputs
    logic               w_ack0, w_ack1, w_err0, w_err1, w_busy, w_ram_wren;
    logic [D_WIDTH-1:0] w_rdata, w_ram_data;
    logic [A_WIDTH-1:0] w_ram_addr;

    // Selected requester fields and helpers
    logic               w_sel;
    logic               w_sel_we;
    logic [1:0]         w_sel_size;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [D_WIDTH-1:0] w_sel_wdata;
    logic               w_sel_word;
    logic               w_sel_bad;
    logic [D_WIDTH-1:0] w_merged;
    logic               w_done;

    // Pick the requester: on a tie the port that was not granted last wins
    always_comb begin
        w_sel       = (req0 && req1) ? ~r_last_grant : req1;
        w_sel_we    = w_sel ? we1    : we0;
        w_sel_size  = w_sel ? size1  : size0;
        w_sel_addr  = w_sel ? addr1  : addr0;
        w_sel_wdata = w_sel ? wdata1 : wdata0;
        w_sel_word  = w_sel_size[1];
        w_sel_bad   = (|w_sel_addr[ADDR_W-1:A_WIDTH+2])
                    | ((w_sel_size == 2'd1) && w_sel_addr[0])
                    | (w_sel_word && (|w_sel_addr[1:0]));
    end

    // Splice store data into the word read back from RAM (little-endian lanes)
    always_comb begin
        w_merged = ram_q;
        if (r_size == 2'd0) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata16[7:0];
                2'd1:    w_merged[15:8]  = r_wdata16[7:0];
                2'd2:    w_merged[23:16] = r_wdata16[7:0];
                default: w_merged[31:24] = r_wdata16[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata16;
        end else begin
            w_merged[15:0]  = r_wdata16;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_owner      = r_owner;
        w_we         = r_we;
        w_size       = r_size;
        w_lane       = r_lane;
        w_wdata16    = r_wdata16;
        w_err        = r_err;
        w_rdata      = rdata;
        w_ram_addr   = ram_addr;
        w_ram_data   = ram_data;
        w_ram_wren   = ram_wren;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_owner   = w_sel;
                    if (req0 && req1) begin
                        w_last_grant = w_sel;
                    end
                    w_we       = w_sel_we;
                    w_size     = w_sel_size;
                    w_lane     = w_sel_addr[1:0];
                    w_wdata16  = w_sel_wdata[15:0];
                    w_err      = w_sel_bad;
                    w_ram_addr = w_sel_addr[A_WIDTH+1:2];
                    // Full-word stores need no read, so write straight away
                    if (!w_sel_bad && w_sel_we && w_sel_word) begin
                        w_ram_data = w_sel_wdata;
                        w_ram_wren = 1'b1;
                    end
                    w_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_err || (r_we && r_size[1])) begin
                    w_done     = 1'b1;
                    w_ram_wren = 1'b0;
                    w_state    = S_IDLE;
                end else begin
                    w_state = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (!r_we) begin
                    w_rdata = ram_q;
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_ram_data = w_merged;
                    w_ram_wren = 1'b1;
                    w_state    = S_WRITE;
                end
            end
            default: begin
                w_done     = 1'b1;
                w_ram_wren = 1'b0;
                w_state    = S_IDLE;
            end
        endcase

        w_ack0 = w_done && !r_owner;
        w_ack1 = w_done &&  r_owner;
        w_err0 = w_ack0 && r_err;
        w_err1 = w_ack1 && r_err;
        w_busy = (w_state != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_lane       <= 2'd0;
            r_wdata16    <= '0;
            r_err        <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
            ram_addr     <= '0;
            ram_data     <= '0;
            ram_wren     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_grant <= w_last_grant;
            r_owner      <= w_owner;
            r_we         <= w_we;
            r_size       <= w_size;
            r_lane       <= w_lane;
            r_wdata16    <= w_wdata16;
            r_err        <= w_err;
            ack0         <= w_ack0;
            ack1         <= w_ack1;
            err0         <= w_err0;
            err1         <= w_err1;
            rdata        <= w_rdata;
            busy         <= w_busy;
            ram_addr     <= w_ram_addr;
            ram_data     <= w_ram_data;
            ram_wren     <= w_ram_wren;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter_ctrl
// Purpose  : Directed self-checking bench for dmem_arbiter_ctrl with a RAM
//            model and an ack scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy, ram_wren;
    logic [31:0] rdata, ram_data, ram_q;
    logic [7:0]  ram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } exp_t;
    exp_t exp_q[$];

    dmem_arbiter_ctrl #(.D_WIDTH(32), .A_WIDTH(8), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Single-port RAM model: address registered, q combinational
    logic [31:0] mem [0:255];
    logic [7:0]  ra_q;
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ra_q <= ram_addr;
    end
    assign ram_q = mem[ra_q];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write-enable activity tracker
    int         wren_total = 0;
    logic [7:0] last_waddr = '0;
    always @(negedge clock) begin
        if (ram_wren) begin
            wren_total++;
            last_waddr = ram_addr;
        end
    end

    // Scoreboard: every ack is matched against the oldest expectation
    always @(negedge clock) begin
        if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {62'd0, ack0, ack1}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_excl", {63'd0, ack0 & ack1}, 64'd0);
                check("ack_port", {63'd0, ack1}, {63'd0, e.port});
                check("err", {63'd0, (e.port ? err1 : err0)}, {63'd0, e.err});
                if (e.chk) check("rdata", {32'd0, rdata}, {32'd0, e.rd});
            end
        end
    end

    // Issue one request at a negedge and wait (bounded) for its ack
    task automatic issue(input logic port, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd,
                         input int e_lat, input int e_wren, input logic [7:0] e_waddr);
        int   n;
        int   w0;
        logic got;
        exp_q.push_back('{port, e_err, (~we & ~e_err), e_rd});
        w0 = wren_total;
        if (port) begin we1 = we; size1 = sz; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else      begin we0 = we; size0 = sz; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            got = port ? ack1 : ack0;
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
        check("latency", 64'(n), 64'(e_lat));
        check("wren_pulses", 64'(wren_total - w0), 64'(e_wren));
        if (e_wren != 0) check("wren_addr", {56'd0, last_waddr}, {56'd0, e_waddr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, m, acks, last, w0;
        logic [31:0] snap0, snap1;

        reset_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; size0 = 0; size1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) @(negedge clock);
        check("reset_flags", {58'd0, ack0, ack1, err0, err1, busy, ram_wren}, 64'd0);
        check("reset_rdata", {32'd0, rdata}, 64'd0);
        check("reset_ram", {24'd0, ram_addr, ram_data}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: word store then word load on port 0
        issue(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 0, 2, 1, 8'h04);
        issue(0, 0, 2'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 0, 8'h00);

        // 2: port 1 byte and half read-modify-write stores
        issue(1, 1, 2'd2, 32'h20, 32'h11223344, 0, 0, 2, 1, 8'h08);
        issue(1, 1, 2'd0, 32'h22, 32'h000000AA, 0, 0, 4, 1, 8'h08);
        check("mem_byte_merge", {32'd0, mem[8]}, {32'd0, 32'h11AA3344});
        issue(1, 1, 2'd1, 32'h20, 32'h0000BEEF, 0, 0, 4, 1, 8'h08);
        check("mem_half_merge", {32'd0, mem[8]}, {32'd0, 32'h11AABEEF});
        issue(1, 0, 2'd2, 32'h20, 32'h0, 0, 32'h11AABEEF, 3, 0, 8'h00);

        // 3: simultaneous, continuously held loads alternate port0/port1
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 32'h11AABEEF});
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 32'h11AABEEF});
        we0 = 0; size0 = 2'd2; addr0 = 32'h10;
        we1 = 0; size1 = 2'd2; addr1 = 32'h20;
        req0 = 1; req1 = 1;
        n = 0; acks = 0; last = 0;
        while (acks < 4 && n < 60) begin
            @(negedge clock);
            n++;
            if (ack0 || ack1) begin
                acks++;
                check("rr_spacing", 64'(n - last), 64'd3);
                last = n;
                if (acks == 4) begin req0 = 0; req1 = 0; end
            end
        end
        req0 = 0; req1 = 0;
        check("rr_ack_count", 64'(acks), 64'd4);

        // 4: misaligned and out-of-range accesses are rejected untouched
        snap0 = mem[0];
        snap1 = mem[1];
        issue(0, 0, 2'd1, 32'h05, 32'h0, 1, 0, 2, 0, 8'h00);
        issue(0, 1, 2'd2, 32'h402, 32'h12345678, 1, 0, 2, 0, 8'h00);
        check("err_mem0", {32'd0, mem[0]}, {32'd0, snap0});
        check("err_mem1", {32'd0, mem[1]}, {32'd0, snap1});
        check("rdata_held", {32'd0, rdata}, {32'd0, 32'h11AABEEF});

        // 5: reset during the read phase of a byte store
        w0 = wren_total;
        we0 = 1; size0 = 2'd0; addr0 = 32'h10; wdata0 = 32'h55; req0 = 1;
        @(negedge clock);
        check("rst_busy_before", {63'd0, busy}, 64'd1);
        @(negedge clock);
        reset_n = 0;
        req0 = 0;
        @(negedge clock);
        check("rst_busy_after", {63'd0, busy}, 64'd0);
        check("rst_no_ack", {62'd0, ack0, ram_wren}, 64'd0);
        reset_n = 1;
        @(negedge clock);
        check("rst_no_wren", 64'(wren_total - w0), 64'd0);
        check("rst_mem", {32'd0, mem[4]}, {32'd0, 32'hDEADBEEF});
        issue(0, 0, 2'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 0, 8'h00);

        // 6: req0 rising while port 1 is being served waits for ack1
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 32'h11AABEEF});
        exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
        we1 = 0; size1 = 2'd2; addr1 = 32'h20; req1 = 1;
        @(negedge clock);
        n = 1;
        we0 = 0; size0 = 2'd2; addr0 = 32'h10; req0 = 1;
        while (!ack1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        req1 = 0;
        check("p1_latency", 64'(n), 64'd3);
        m = 0;
        while (!ack0 && m < 20) begin
            @(negedge clock);
            m++;
        end
        req0 = 0;
        check("p0_after_ack1", 64'(m), 64'd3);
        check("p0_rdata", {32'd0, rdata}, {32'd0, 32'hDEADBEEF});

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
